// File: rtl/bcd_disp_fmt_pkg.sv
// Shared constants and types for the BCD display formatter.
package bcd_disp_pkg;

  // Bus word addresses
  localparam logic [11:0] ADDR_RAW  = 12'h000;
  localparam logic [11:0] ADDR_BIN  = 12'h010;
  localparam logic [11:0] ADDR_STAT = 12'h014;

  // Binary width converted; 2^27 covers 99_999_999
  localparam int NBITS = 27;

  // Result shown when the value does not fit in 8 decimal digits
  localparam logic [31:0] OVF_PATTERN = 32'hEEEEEEEE;
  localparam logic [31:0] BIN_MAX     = 32'd99_999_999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_disp_fmt_if.sv
// CPU peripheral bus plus display-register write port of the formatter.
interface bcd_disp_fmt_if;
  logic        wen;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        disp_wen;
  logic [11:0] disp_addr;
  logic [31:0] disp_wdata;

  modport master (
    output wen, addr, wdata,
    input  rdata, disp_wen, disp_addr, disp_wdata
  );

  modport slave (
    input  wen, addr, wdata,
    output rdata, disp_wen, disp_addr, disp_wdata
  );
endinterface

// File: rtl/bcd_disp_fmt_digit_adj.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added so the
// following left shift carries into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);
  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
endmodule

// File: rtl/bcd_disp_fmt.sv
// Bus-mapped formatter: binary writes become packed BCD via a one-shift-per-
// cycle double-dabble engine; raw writes pass straight to the display.
module bcd_disp_fmt
  import bcd_disp_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  bcd_disp_fmt_if.slave  bus
);

  localparam logic [4:0] CNT_LAST = 5'(NBITS - 1);

  state_t           r_state, w_state_next;
  logic [NBITS-1:0] r_shift, w_shift_next;
  logic [31:0]      r_bcd, w_bcd_next;
  logic [31:0]      w_bcd_adj;
  logic [4:0]       r_cnt, w_cnt_next;
  // Overflow results wait one extra cycle in DONE before issuing
  logic             r_hold, w_hold_next;
  logic             r_dropped, w_dropped_next;
  // Raw writes are staged one cycle, then issued ahead of any BCD result
  logic             r_raw_pend, w_raw_pend_next;
  logic [31:0]      r_raw_data, w_raw_data_next;
  logic             r_disp_wen, w_disp_wen_next;
  logic [11:0]      r_disp_addr, w_disp_addr_next;
  logic [31:0]      r_disp_wdata, w_disp_wdata_next;

  logic w_wr_raw, w_wr_bin, w_wr_stat, w_busy;

  assign w_wr_raw  = bus.wen && (bus.addr == ADDR_RAW);
  assign w_wr_bin  = bus.wen && (bus.addr == ADDR_BIN);
  assign w_wr_stat = bus.wen && (bus.addr == ADDR_STAT);
  assign w_busy    = (r_state != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_bcd[4*gi +: 4]),
        .o_digit (w_bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_hold       <= 1'b0;
      r_dropped    <= 1'b0;
      r_raw_pend   <= 1'b0;
      r_raw_data   <= '0;
      r_disp_wen   <= 1'b0;
      r_disp_addr  <= '0;
      r_disp_wdata <= '0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bcd        <= w_bcd_next;
      r_cnt        <= w_cnt_next;
      r_hold       <= w_hold_next;
      r_dropped    <= w_dropped_next;
      r_raw_pend   <= w_raw_pend_next;
      r_raw_data   <= w_raw_data_next;
      r_disp_wen   <= w_disp_wen_next;
      r_disp_addr  <= w_disp_addr_next;
      r_disp_wdata <= w_disp_wdata_next;
    end
  end

  // Next-state, conversion step, and display write arbitration
  always_comb begin
    w_state_next      = r_state;
    w_shift_next      = r_shift;
    w_bcd_next        = r_bcd;
    w_cnt_next        = r_cnt;
    w_hold_next       = r_hold;
    w_dropped_next    = r_dropped;
    w_raw_pend_next   = w_wr_raw;
    w_raw_data_next   = w_wr_raw ? bus.wdata : r_raw_data;
    w_disp_wen_next   = 1'b0;
    w_disp_addr_next  = r_disp_addr;
    w_disp_wdata_next = r_disp_wdata;

    if (r_raw_pend) begin
      w_disp_wen_next   = 1'b1;
      w_disp_addr_next  = ADDR_RAW;
      w_disp_wdata_next = r_raw_data;
    end

    if (w_wr_stat) begin
      w_dropped_next = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_wr_bin) begin
          if (bus.wdata > BIN_MAX) begin
            w_bcd_next   = OVF_PATTERN;
            w_hold_next  = 1'b1;
            w_state_next = DONE;
          end else begin
            w_shift_next = bus.wdata[NBITS-1:0];
            w_bcd_next   = '0;
            w_cnt_next   = '0;
            w_state_next = CONV;
          end
        end
      end
      CONV: begin
        if (w_wr_bin) begin
          w_dropped_next = 1'b1;
        end
        w_bcd_next   = {w_bcd_adj[30:0], r_shift[NBITS-1]};
        w_shift_next = {r_shift[NBITS-2:0], 1'b0};
        w_cnt_next   = r_cnt + 5'd1;
        if (r_cnt == CNT_LAST) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (w_wr_bin) begin
          w_dropped_next = 1'b1;
        end
        if (r_hold) begin
          w_hold_next = 1'b0;
        end else if (!r_raw_pend) begin
          w_disp_wen_next   = 1'b1;
          w_disp_addr_next  = ADDR_RAW;
          w_disp_wdata_next = r_bcd;
          w_state_next      = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.rdata      = (bus.addr == ADDR_STAT) ? {30'b0, r_dropped, w_busy} : 32'b0;
  assign bus.disp_wen   = r_disp_wen;
  assign bus.disp_addr  = r_disp_addr;
  assign bus.disp_wdata = r_disp_wdata;

endmodule

// File: tb/tb_bcd_disp_fmt.sv
// Bench for bcd_disp_fmt: directed and random writes against a decimal
// reference model; every display write is matched to an expected edge.
module tb_bcd_disp_fmt;
  import bcd_disp_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  bcd_disp_fmt_if bus ();

  bcd_disp_fmt u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int cyc_cnt  = 0;
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_data [int];

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  // Decimal digits by plain arithmetic; out-of-range values show the E pattern
  function automatic logic [31:0] ref_fmt(input logic [31:0] v);
    int unsigned x;
    logic [31:0] r;
    if (v > 32'd99_999_999) return 32'hEEEEEEEE;
    x = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [31:0] v);
    return (v > 32'd99_999_999) ? 2 : 28;
  endfunction

  // Every display write must land on an edge the bench scheduled
  always @(posedge clk_i) begin
    #1;
    if (bus.disp_wen === 1'b1) begin
      $display("disp write at edge %0d: addr 0x%03h data 0x%08h", cyc_cnt, bus.disp_addr, bus.disp_wdata);
      chk("disp_addr", {20'b0, bus.disp_addr}, 32'h0);
      if (exp_data.exists(cyc_cnt)) begin
        chk("disp_wdata", bus.disp_wdata, exp_data[cyc_cnt]);
        exp_data.delete(cyc_cnt);
      end else begin
        chk("unexpected_disp_wen", {31'b0, bus.disp_wen}, 32'h0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_edge(input int e);
    while (cyc_cnt < e) tick(1);
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d, output int acc);
    bus.wen   = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk_i);
    #1;
    acc      = cyc_cnt;
    bus.wen  = 1'b0;
    bus.addr = 12'h0;
  endtask

  task automatic read_stat(output logic [31:0] v);
    bus.wen  = 1'b0;
    bus.addr = ADDR_STAT;
    #1;
    v = bus.rdata;
    bus.addr = 12'h0;
  endtask

  task automatic run_bin(input logic [31:0] v);
    int acc, lat;
    logic [31:0] s;
    bus_write(ADDR_BIN, v, acc);
    lat = ref_lat(v);
    exp_data[acc + lat] = ref_fmt(v);
    $display("bin write 0x%08h accepted at edge %0d", v, acc);
    read_stat(s);
    chk("busy_after_accept", s, 32'h1);
    wait_edge(acc + lat - 1);
    read_stat(s);
    chk("busy_before_issue", s, 32'h1);
    wait_edge(acc + lat);
    read_stat(s);
    chk("idle_after_issue", s, 32'h0);
    tick(1);
  endtask

  initial begin
    int acc, a, a2, e, lat, k;
    logic [31:0] s, v, r;

    bus.wen   = 1'b0;
    bus.addr  = 12'h0;
    bus.wdata = 32'h0;
    rst_i     = 1'b1;
    tick(3);
    chk("rst_disp_wen", {31'b0, bus.disp_wen}, 32'h0);
    chk("rst_disp_addr", {20'b0, bus.disp_addr}, 32'h0);
    chk("rst_disp_wdata", bus.disp_wdata, 32'h0);
    read_stat(s);
    chk("rst_status", s, 32'h0);
    rst_i = 1'b0;
    tick(2);

    // Directed conversions, boundary values and overflow
    run_bin(32'd12_345_678);
    run_bin(32'd0);
    run_bin(32'd99_999_999);
    run_bin(32'd100_000_000);
    run_bin(32'hFFFFFFFF);

    // Raw pass-through while idle
    bus_write(ADDR_RAW, 32'h0000ABCD, a);
    exp_data[a + 1] = 32'h0000ABCD;
    tick(3);

    // Raw pass-through in the middle of a conversion
    bus_write(ADDR_BIN, 32'd87_654_321, acc);
    exp_data[acc + 28] = ref_fmt(32'd87_654_321);
    tick(9);
    bus_write(ADDR_RAW, 32'h0000ABCD, a);
    exp_data[a + 1] = 32'h0000ABCD;
    wait_edge(acc + 29);

    // Second conversion request while busy is dropped and flagged
    bus_write(ADDR_BIN, 32'd24_680, acc);
    exp_data[acc + 28] = ref_fmt(32'd24_680);
    tick(4);
    bus_write(ADDR_BIN, 32'd13_579, a2);
    read_stat(s);
    chk("status_dropped", s, 32'h3);
    bus_write(ADDR_STAT, 32'h0, a);
    read_stat(s);
    chk("status_cleared_busy", s, 32'h1);
    wait_edge(acc + 28);
    read_stat(s);
    chk("status_cleared_idle", s, 32'h0);
    tick(2);

    // Raw write issued on the same edge as the BCD result
    bus_write(ADDR_BIN, 32'd55_555, acc);
    e = acc + 28;
    wait_edge(acc + 26);
    bus_write(ADDR_RAW, 32'h00001234, a);
    exp_data[a + 1] = 32'h00001234;
    if (a + 1 == e) e++;
    exp_data[e] = ref_fmt(32'd55_555);
    wait_edge(e);
    tick(2);

    // Back-to-back raw writes
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      bus_write(ADDR_RAW, r, a);
      exp_data[a + 1] = r;
    end
    tick(3);

    // Randomized conversions with an optional raw write during each one
    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 99_999_999));
      bus_write(ADDR_BIN, v, acc);
      lat = ref_lat(v);
      e = acc + lat;
      $display("bin write 0x%08h accepted at edge %0d", v, acc);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, lat - 1);
        wait_edge(acc + k - 1);
        r = $urandom;
        bus_write(ADDR_RAW, r, a);
        exp_data[a + 1] = r;
        if (a + 1 == e) e++;
      end
      exp_data[e] = ref_fmt(v);
      wait_edge(e);
      tick(1);
    end

    // Reset in the middle of a conversion aborts it silently
    bus_write(ADDR_BIN, 32'd424_242, acc);
    wait_edge(acc + 10);
    rst_i = 1'b1;
    #1;
    chk("abort_disp_wen", {31'b0, bus.disp_wen}, 32'h0);
    chk("abort_disp_wdata", bus.disp_wdata, 32'h0);
    read_stat(s);
    chk("abort_status", s, 32'h0);
    tick(2);
    rst_i = 1'b0;
    tick(35);

    chk("pending_writes", 32'(exp_data.num()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_disp_fmt.md
# bcd_disp_fmt

Memory-mapped formatter that sits between the CPU peripheral bus and the 8-digit seven-segment display register. A CPU binary write is converted to packed BCD by a sequential double-dabble engine (one shift per cycle). The result is issued as a single display-register write, so software can print decimal values. Raw hex writes pass straight through, so the display still accepts hex nibbles directly.

## Interface
- ADDR_RAW, 12'h000, raw pass-through address; also the display-register address driven on disp_addr
- ADDR_BIN, 12'h010, binary-to-decimal conversion request address
- ADDR_STAT, 12'h014, status register address
- NBITS, 27, binary width converted (2^27 > 99_999_999)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- wen  in  1  bus write strobe, single-cycle
- addr  in  12  bus word address
- wdata  in  32  bus write data
- rdata  out  32  combinational read data: {30'b0, dropped, busy} when addr==ADDR_STAT, else 0
- disp_wen  out  1  display write strobe, one cycle per write
- disp_addr  out  12  display write address, always ADDR_RAW when disp_wen=1
- disp_wdata  out  32  display write data, 8 packed 4-bit digits, digit 0 in [3:0]

## Operation
- States: IDLE, CONV, DONE.
- IDLE, wen & addr==ADDR_BIN:
  - If wdata ≥ 100_000_000, queue result 0xEEEEEEEE directly. State goes to DONE; CONV is skipped.
  - Otherwise load shift reg = wdata[NBITS-1:0], bcd = 0, cnt = 0. State goes to CONV.
- CONV: each cycle, every BCD digit ≥5 gets +3, then {bcd,shift} shifts left 1 and cnt increments. After NBITS iterations, state goes to DONE.
- DONE: issue disp write with bcd, then return to IDLE. If a raw write is issued in the same cycle, stay in DONE one more cycle.
- wen & addr==ADDR_RAW in any state: issue disp write of wdata on the next edge. Raw writes have priority over a DONE issue.
- wen & addr==ADDR_BIN while in CONV or DONE: the request is dropped and the sticky dropped bit is set. The in-flight conversion is unaffected.
- wen & addr==ADDR_STAT: clears dropped. Bus writes to any other address are ignored.
- busy = (state != IDLE).
- Reset values: state IDLE, disp_wen 0, disp_addr 0, disp_wdata 0, dropped 0, internal shift/bcd/cnt 0.
- Reset mid-conversion aborts it. No disp write is issued for the aborted conversion.

## Timing
- All disp_* outputs are registered. disp_wen is high for exactly one cycle per issued write.
- Raw pass-through: a write accepted at edge N drives disp_wen high after edge N+1.
- Conversion accepted at edge N: iterations occur at edges N+1..N+27, DONE is entered at edge N+27, and disp_wen goes high after edge N+28. busy is high from after edge N until after edge N+28.
- Overflow accepted at edge N: disp_wen goes high after edge N+2.
- Raw write and DONE issue at the same edge: the raw write is issued first, and the BCD result follows on the next edge.
- Back-to-back raw writes each produce one disp write, with no loss.
- rdata has zero latency and reflects registered status.

## Structure
- Package bcd_disp_pkg holds:
  - address constants ADDR_RAW/ADDR_BIN/ADDR_STAT
  - the state enum (IDLE/CONV/DONE)
  - OVF_PATTERN = 32'hEEEEEEEE
  - BIN_MAX = 99_999_999
- Sub-module bcd_digit_adj: combinational 4-bit "if ≥5 add 3" cell, instantiated 8×.

## Test plan
- Write 12_345_678 to ADDR_BIN -> after 28 edges, one-cycle disp_wen with disp_addr 0x000 and disp_wdata 0x12345678. rdata at ADDR_STAT reads 0x1 while converting.
- Write 0, then 99_999_999 -> disp_wdata 0x00000000, then 0x99999999, each 28 cycles after its accept.
- Write 100_000_000, and separately 0xFFFFFFFF -> disp_wdata 0xEEEEEEEE after edge N+2, with busy high for only 2 cycles.
- Raw write 0x0000ABCD to ADDR_RAW, while idle and again mid-conversion -> disp_wdata 0x0000ABCD one edge later, and the conversion result still arrives on schedule.
- Second ADDR_BIN write mid-conversion -> status reads 0x3, and only the first result is issued. A write to ADDR_STAT then gives status 0x1/0x0.
- Raw write timed to coincide with DONE -> raw data issued first, BCD on the next edge. Separately, assert rst_i at cycle 10 of a conversion -> no disp_wen, all outputs 0.
